// File: rtl/alu_rs_queue.sv
// ALU reservation station: a DEPTH-entry queue that captures operands from the CDB,
// picks the oldest ready op through an age matrix and issues it on registered outputs.
module alu_rs_queue #(
  parameter int WIDTH  = 32,
  parameter int ROB_W  = 3,
  parameter int CTRL_W = 4,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              globalReset,
  input  logic              dispatchValid,
  output logic              dispatchReady,
  input  logic              ready1,
  input  logic              ready2,
  input  logic [WIDTH-1:0]  value1,
  input  logic [WIDTH-1:0]  value2,
  input  logic [ROB_W-1:0]  rob1,
  input  logic [ROB_W-1:0]  rob2,
  input  logic [ROB_W-1:0]  robInstr,
  input  logic [CTRL_W-1:0] aluControl,
  input  logic              cdbValid,
  input  logic [ROB_W-1:0]  cdbRob,
  input  logic [WIDTH-1:0]  cdbValue,
  input  logic              flush,
  input  logic              execute,
  output logic              issueValid,
  output logic [ROB_W-1:0]  issueRob,
  output logic [CTRL_W-1:0] issueInfo,
  output logic [WIDTH-1:0]  issueSrc1,
  output logic [WIDTH-1:0]  issueSrc2,
  output logic [CNT_W-1:0]  freeCount,
  output logic              empty
);

  logic [DEPTH-1:0]             valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [ROB_W-1:0]             tag1_q [DEPTH];
  logic [ROB_W-1:0]             tag1_d [DEPTH];
  logic [ROB_W-1:0]             tag2_q [DEPTH];
  logic [ROB_W-1:0]             tag2_d [DEPTH];
  logic [WIDTH-1:0]             val1_q [DEPTH];
  logic [WIDTH-1:0]             val1_d [DEPTH];
  logic [WIDTH-1:0]             val2_q [DEPTH];
  logic [WIDTH-1:0]             val2_d [DEPTH];
  logic [ROB_W-1:0]             rob_q  [DEPTH];
  logic [ROB_W-1:0]             rob_d  [DEPTH];
  logic [CTRL_W-1:0]            ctrl_q [DEPTH];
  logic [CTRL_W-1:0]            ctrl_d [DEPTH];
  logic [DEPTH-1:0][DEPTH-1:0]  age_q, age_d;

  logic              issueValid_q, issueValid_d;
  logic [ROB_W-1:0]  issueRob_q, issueRob_d;
  logic [CTRL_W-1:0] issueInfo_q, issueInfo_d;
  logic [WIDTH-1:0]  issueSrc1_q, issueSrc1_d, issueSrc2_q, issueSrc2_d;

  logic [DEPTH-1:0]  req, sel, allocOh;
  logic              anyReq, allocFound, doAlloc, doIssue, byp1, byp2;
  logic [CNT_W-1:0]  freeCnt;
  logic [ROB_W-1:0]  selRob;
  logic [CTRL_W-1:0] selCtrl;
  logic [WIDTH-1:0]  selSrc1, selSrc2;

  always_comb begin
    freeCnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_q[i]) freeCnt = freeCnt + CNT_W'(1);
    end
  end

  assign freeCount     = freeCnt;
  assign dispatchReady = (freeCnt != '0);
  assign empty         = (valid_q == '0);

  // Row i of the age matrix marks entries older than i; a requester wins only
  // when none of its older entries is also requesting.
  always_comb begin
    req = valid_q & rdy1_q & rdy2_q;
    for (int i = 0; i < DEPTH; i++) begin
      sel[i] = req[i] & ~|(req & age_q[i]);
    end
  end

  assign anyReq = |req;

  always_comb begin
    allocOh    = '0;
    allocFound = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!allocFound && !valid_q[i]) begin
        allocOh[i] = 1'b1;
        allocFound = 1'b1;
      end
    end
  end

  assign doAlloc = dispatchValid & dispatchReady & ~flush;
  assign doIssue = execute & anyReq & ~flush;
  assign byp1    = ~ready1 & cdbValid & (cdbRob == rob1);
  assign byp2    = ~ready2 & cdbValid & (cdbRob == rob2);

  always_comb begin
    selRob  = '0;
    selCtrl = '0;
    selSrc1 = '0;
    selSrc2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      selRob  = selRob  | ({ROB_W{sel[i]}}  & rob_q[i]);
      selCtrl = selCtrl | ({CTRL_W{sel[i]}} & ctrl_q[i]);
      selSrc1 = selSrc1 | ({WIDTH{sel[i]}}  & val1_q[i]);
      selSrc2 = selSrc2 | ({WIDTH{sel[i]}}  & val2_q[i]);
    end
  end

  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    tag1_d  = tag1_q;
    tag2_d  = tag2_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    rob_d   = rob_q;
    ctrl_d  = ctrl_q;
    age_d   = age_q;
    if (doAlloc) begin
      for (int j = 0; j < DEPTH; j++) age_d[j] = age_d[j] & ~allocOh;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cdbValid && valid_q[i] && !rdy1_q[i] && (tag1_q[i] == cdbRob)) begin
        rdy1_d[i] = 1'b1;
        val1_d[i] = cdbValue;
      end
      if (cdbValid && valid_q[i] && !rdy2_q[i] && (tag2_q[i] == cdbRob)) begin
        rdy2_d[i] = 1'b1;
        val2_d[i] = cdbValue;
      end
      if (doIssue && sel[i]) valid_d[i] = 1'b0;
      if (doAlloc && allocOh[i]) begin
        valid_d[i] = 1'b1;
        rdy1_d[i]  = ready1 | byp1;
        rdy2_d[i]  = ready2 | byp2;
        tag1_d[i]  = rob1;
        tag2_d[i]  = rob2;
        val1_d[i]  = byp1 ? cdbValue : value1;
        val2_d[i]  = byp2 ? cdbValue : value2;
        rob_d[i]   = robInstr;
        ctrl_d[i]  = aluControl;
        age_d[i]   = valid_q;
      end
    end
    if (flush) begin
      valid_d = '0;
      age_d   = '0;
    end
  end

  // Issue stage holds while the ALU stalls; a flush or an empty select loads the bubble.
  always_comb begin
    issueValid_d = issueValid_q;
    issueRob_d   = issueRob_q;
    issueInfo_d  = issueInfo_q;
    issueSrc1_d  = issueSrc1_q;
    issueSrc2_d  = issueSrc2_q;
    if (flush || (execute && !anyReq)) begin
      issueValid_d = 1'b0;
      issueRob_d   = '0;
      issueInfo_d  = '1;
      issueSrc1_d  = '0;
      issueSrc2_d  = '0;
    end else if (execute) begin
      issueValid_d = 1'b1;
      issueRob_d   = selRob;
      issueInfo_d  = selCtrl;
      issueSrc1_d  = selSrc1;
      issueSrc2_d  = selSrc2;
    end
  end

  always_ff @(posedge clk or negedge globalReset) begin
    if (!globalReset) begin
      valid_q      <= '0;
      rdy1_q       <= '0;
      rdy2_q       <= '0;
      age_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag1_q[i] <= '0;
        tag2_q[i] <= '0;
        val1_q[i] <= '0;
        val2_q[i] <= '0;
        rob_q[i]  <= '0;
        ctrl_q[i] <= '0;
      end
      issueValid_q <= 1'b0;
      issueRob_q   <= '0;
      issueInfo_q  <= '1;
      issueSrc1_q  <= '0;
      issueSrc2_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      rdy1_q       <= rdy1_d;
      rdy2_q       <= rdy2_d;
      age_q        <= age_d;
      tag1_q       <= tag1_d;
      tag2_q       <= tag2_d;
      val1_q       <= val1_d;
      val2_q       <= val2_d;
      rob_q        <= rob_d;
      ctrl_q       <= ctrl_d;
      issueValid_q <= issueValid_d;
      issueRob_q   <= issueRob_d;
      issueInfo_q  <= issueInfo_d;
      issueSrc1_q  <= issueSrc1_d;
      issueSrc2_q  <= issueSrc2_d;
    end
  end

  assign issueValid = issueValid_q;
  assign issueRob   = issueRob_q;
  assign issueInfo  = issueInfo_q;
  assign issueSrc1  = issueSrc1_q;
  assign issueSrc2  = issueSrc2_q;

endmodule

// File: tb/tb_alu_rs_queue.sv
// Bench for alu_rs_queue: directed scenarios plus random traffic checked against
// an age-ordered queue model of the reservation station.
module tb_alu_rs_queue;
  localparam int WIDTH  = 32;
  localparam int ROB_W  = 3;
  localparam int CTRL_W = 4;
  localparam int DEPTH  = 8;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              globalReset = 1'b0;
  logic              dispatchValid, dispatchReady, ready1, ready2;
  logic [WIDTH-1:0]  value1, value2, cdbValue, issueSrc1, issueSrc2;
  logic [ROB_W-1:0]  rob1, rob2, robInstr, cdbRob, issueRob;
  logic [CTRL_W-1:0] aluControl, issueInfo;
  logic              cdbValid, flush, execute, issueValid, empty;
  logic [CNT_W-1:0]  freeCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_rs_queue #(.WIDTH(WIDTH), .ROB_W(ROB_W), .CTRL_W(CTRL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .globalReset(globalReset), .dispatchValid(dispatchValid), .dispatchReady(dispatchReady),
    .ready1(ready1), .ready2(ready2), .value1(value1), .value2(value2), .rob1(rob1), .rob2(rob2),
    .robInstr(robInstr), .aluControl(aluControl), .cdbValid(cdbValid), .cdbRob(cdbRob),
    .cdbValue(cdbValue), .flush(flush), .execute(execute), .issueValid(issueValid),
    .issueRob(issueRob), .issueInfo(issueInfo), .issueSrc1(issueSrc1), .issueSrc2(issueSrc2),
    .freeCount(freeCount), .empty(empty)
  );

  typedef struct {
    bit                r1, r2;
    logic [ROB_W-1:0]  t1, t2, rob;
    logic [WIDTH-1:0]  v1, v2;
    logic [CTRL_W-1:0] ctrl;
  } ent_t;

  // Queue order is dispatch order, so the oldest ready op is the first ready element.
  ent_t              mq[$];
  logic              mValid;
  logic [ROB_W-1:0]  mRob;
  logic [CTRL_W-1:0] mInfo;
  logic [WIDTH-1:0]  mS1, mS2;

  task automatic modelBubble();
    mValid = 1'b0; mRob = '0; mInfo = '1; mS1 = '0; mS2 = '0;
  endtask

  task automatic modelEdge();
    int   pick;
    bit   canDisp;
    ent_t e;
    if (flush) begin
      mq.delete();
      modelBubble();
      return;
    end
    pick = -1;
    foreach (mq[i]) if (pick < 0 && mq[i].r1 && mq[i].r2) pick = i;
    canDisp = dispatchValid && (mq.size() < DEPTH);
    if (execute) begin
      if (pick >= 0) begin
        mValid = 1'b1; mRob = mq[pick].rob; mInfo = mq[pick].ctrl;
        mS1 = mq[pick].v1; mS2 = mq[pick].v2;
      end else modelBubble();
    end
    if (cdbValid) begin
      foreach (mq[i]) begin
        if (!mq[i].r1 && mq[i].t1 == cdbRob) begin mq[i].r1 = 1; mq[i].v1 = cdbValue; end
        if (!mq[i].r2 && mq[i].t2 == cdbRob) begin mq[i].r2 = 1; mq[i].v2 = cdbValue; end
      end
    end
    if (execute && pick >= 0) mq.delete(pick);
    if (canDisp) begin
      e.r1 = ready1 || (cdbValid && cdbRob == rob1);
      e.r2 = ready2 || (cdbValid && cdbRob == rob2);
      e.v1 = ready1 ? value1 : cdbValue;
      e.v2 = ready2 ? value2 : cdbValue;
      e.t1 = rob1; e.t2 = rob2; e.rob = robInstr; e.ctrl = aluControl;
      mq.push_back(e);
    end
  endtask

  task automatic tick();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setIdle();
    dispatchValid = 0; ready1 = 0; ready2 = 0; value1 = '0; value2 = '0; rob1 = '0; rob2 = '0;
    robInstr = '0; aluControl = '0; cdbValid = 0; cdbRob = '0; cdbValue = '0; flush = 0; execute = 1;
  endtask

  task automatic setOp(input bit r1, input int v1, input int t1, input bit r2, input int v2,
                       input int t2, input int rob, input int ctrl);
    dispatchValid = 1; ready1 = r1; value1 = WIDTH'(v1); rob1 = ROB_W'(t1);
    ready2 = r2; value2 = WIDTH'(v2); rob2 = ROB_W'(t2);
    robInstr = ROB_W'(rob); aluControl = CTRL_W'(ctrl);
  endtask

  task automatic setCdb(input int tag, input int val);
    cdbValid = 1; cdbRob = ROB_W'(tag); cdbValue = WIDTH'(val);
  endtask

  task automatic applyReset();
    setIdle();
    #1 globalReset = 0;
    mq.delete();
    modelBubble();
    @(posedge clk);
    #1 globalReset = 1;
  endtask

  task automatic test_reset();
    applyReset();
    total++; if (issueValid !== 1'b0) begin bad++; $display("[TB] FAIL reset.valid got=%0h want=0", issueValid); end
    total++; if (issueInfo !== 4'hF) begin bad++; $display("[TB] FAIL reset.info got=%0h want=f", issueInfo); end
    total++; if (issueRob !== '0) begin bad++; $display("[TB] FAIL reset.rob got=%0h want=0", issueRob); end
    total++; if (issueSrc1 !== '0 || issueSrc2 !== '0) begin bad++; $display("[TB] FAIL reset.src got=%0h/%0h want=0/0", issueSrc1, issueSrc2); end
    total++; if (freeCount !== CNT_W'(DEPTH)) begin bad++; $display("[TB] FAIL reset.free got=%0d want=%0d", freeCount, DEPTH); end
    total++; if (empty !== 1'b1 || dispatchReady !== 1'b1) begin bad++; $display("[TB] FAIL reset.flags got=%0b%0b want=11", empty, dispatchReady); end
  endtask

  task automatic test_basic_issue();
    applyReset();
    setOp(1, 5, 0, 1, 7, 0, 2, 3); tick(); setIdle();
    total++; if (freeCount !== CNT_W'(DEPTH-1)) begin bad++; $display("[TB] FAIL basic.freeAfterDisp got=%0d want=%0d", freeCount, DEPTH-1); end
    total++; if (issueValid !== 1'b0) begin bad++; $display("[TB] FAIL basic.noIssueYet got=%0h want=0", issueValid); end
    tick();
    total++; if (issueValid !== 1'b1 || issueRob !== 3'd2 || issueInfo !== 4'd3) begin bad++; $display("[TB] FAIL basic.issue got=%0h/%0h/%0h want=1/2/3", issueValid, issueRob, issueInfo); end
    total++; if (issueSrc1 !== 32'd5 || issueSrc2 !== 32'd7) begin bad++; $display("[TB] FAIL basic.src got=%0d/%0d want=5/7", issueSrc1, issueSrc2); end
    total++; if (freeCount !== CNT_W'(DEPTH)) begin bad++; $display("[TB] FAIL basic.free got=%0d want=%0d", freeCount, DEPTH); end
  endtask

  task automatic test_cdb_wakeup();
    applyReset();
    setOp(1, 1, 0, 0, 0, 4, 5, 2); tick(); setIdle();
    setCdb(4, 99); tick(); setIdle();
    total++; if (issueValid !== 1'b0) begin bad++; $display("[TB] FAIL wake.noComb got=%0h want=0", issueValid); end
    tick();
    total++; if (issueValid !== 1'b1 || issueRob !== 3'd5 || issueSrc2 !== 32'd99) begin bad++; $display("[TB] FAIL wake.issue got=%0h/%0h/%0d want=1/5/99", issueValid, issueRob, issueSrc2); end
    setOp(1, 1, 0, 0, 0, 4, 6, 2); setCdb(4, 77); tick(); setIdle();
    tick();
    total++; if (issueValid !== 1'b1 || issueRob !== 3'd6 || issueSrc2 !== 32'd77) begin bad++; $display("[TB] FAIL bypass.issue got=%0h/%0h/%0d want=1/6/77", issueValid, issueRob, issueSrc2); end
  endtask

  task automatic test_age_order();
    logic [ROB_W-1:0] expRob [3];
    expRob = '{3'd1, 3'd2, 3'd3};
    applyReset();
    setOp(1, 0, 0, 0, 0, 5, 4, 0); tick();
    setOp(1, 0, 0, 0, 0, 5, 5, 0); tick();
    setOp(1, 10, 0, 0, 0, 6, 1, 1); tick(); setIdle();
    setCdb(5, 0); tick(); setIdle();
    tick(); tick();
    setOp(1, 20, 0, 0, 0, 6, 2, 1); tick();
    setOp(1, 30, 0, 0, 0, 6, 3, 1); tick(); setIdle();
    setCdb(6, 42); tick(); setIdle();
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (issueValid !== 1'b1 || issueRob !== expRob[k] || issueSrc2 !== 32'd42) begin bad++; $display("[TB] FAIL age.order%0d got=%0h/%0h/%0d want=1/%0h/42", k, issueValid, issueRob, issueSrc2, expRob[k]); end
    end
  endtask

  task automatic test_full();
    applyReset();
    for (int k = 0; k < DEPTH; k++) begin
      setOp(1, k, 0, 0, 0, 7, k, 1); tick();
    end
    setIdle();
    total++; if (dispatchReady !== 1'b0 || freeCount !== '0) begin bad++; $display("[TB] FAIL full.flags got=%0b/%0d want=0/0", dispatchReady, freeCount); end
    setOp(1, 9, 0, 1, 9, 0, 0, 2); tick(); setIdle();
    total++; if (freeCount !== '0 || issueValid !== 1'b0) begin bad++; $display("[TB] FAIL full.ignored got=%0d/%0h want=0/0", freeCount, issueValid); end
    setCdb(7, 55); tick();
    setOp(1, 9, 0, 1, 9, 0, 7, 2); tick(); setIdle();
    total++; if (issueValid !== 1'b1 || issueRob !== 3'd0 || issueSrc1 !== 32'd0) begin bad++; $display("[TB] FAIL full.oldest got=%0h/%0h/%0d want=1/0/0", issueValid, issueRob, issueSrc1); end
    total++; if (freeCount !== CNT_W'(1) || dispatchReady !== 1'b1) begin bad++; $display("[TB] FAIL full.freed got=%0d/%0b want=1/1", freeCount, dispatchReady); end
    tick();
    total++; if (issueRob !== 3'd1 || freeCount !== CNT_W'(2)) begin bad++; $display("[TB] FAIL full.next got=%0h/%0d want=1/2", issueRob, freeCount); end
  endtask

  task automatic test_stall();
    applyReset();
    setOp(1, 11, 0, 1, 22, 0, 1, 5); tick();
    setOp(1, 33, 0, 1, 44, 0, 2, 6); tick(); setIdle();
    execute = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (issueValid !== 1'b1 || issueRob !== 3'd1 || issueSrc1 !== 32'd11 || freeCount !== CNT_W'(DEPTH-1)) begin bad++; $display("[TB] FAIL stall.hold%0d got=%0h/%0h/%0d/%0d want=1/1/11/%0d", k, issueValid, issueRob, issueSrc1, freeCount, DEPTH-1); end
    end
    execute = 1; tick();
    total++; if (issueRob !== 3'd2 || issueSrc1 !== 32'd33 || issueInfo !== 4'd6 || freeCount !== CNT_W'(DEPTH)) begin bad++; $display("[TB] FAIL stall.resume got=%0h/%0d/%0h/%0d want=2/33/6/%0d", issueRob, issueSrc1, issueInfo, freeCount, DEPTH); end
  endtask

  task automatic test_flush_reset();
    applyReset();
    for (int k = 0; k < 3; k++) begin
      setOp(1, k, 0, 0, 0, 3, k, 2); tick();
    end
    setOp(1, 1, 0, 1, 2, 0, 5, 1); setCdb(3, 8); flush = 1; tick(); setIdle();
    total++; if (empty !== 1'b1 || freeCount !== CNT_W'(DEPTH)) begin bad++; $display("[TB] FAIL flush.state got=%0b/%0d want=1/%0d", empty, freeCount, DEPTH); end
    total++; if (issueValid !== 1'b0 || issueInfo !== 4'b1111) begin bad++; $display("[TB] FAIL flush.bubble got=%0h/%0h want=0/f", issueValid, issueInfo); end
    setOp(1, 3, 0, 1, 4, 0, 6, 7); tick();
    setOp(0, 0, 2, 1, 4, 0, 7, 7); tick(); setIdle();
    total++; if (issueValid !== 1'b1 || issueRob !== 3'd6) begin bad++; $display("[TB] FAIL flush.refill got=%0h/%0h want=1/6", issueValid, issueRob); end
    #2 globalReset = 0;
    #1;
    mq.delete();
    modelBubble();
    total++; if (issueValid !== 1'b0 || issueInfo !== 4'hF || issueRob !== '0 || issueSrc1 !== '0) begin bad++; $display("[TB] FAIL areset.bubble got=%0h/%0h/%0h/%0d want=0/f/0/0", issueValid, issueInfo, issueRob, issueSrc1); end
    total++; if (empty !== 1'b1 || freeCount !== CNT_W'(DEPTH)) begin bad++; $display("[TB] FAIL areset.state got=%0b/%0d want=1/%0d", empty, freeCount, DEPTH); end
    @(posedge clk);
    #1 globalReset = 1;
  endtask

  task automatic test_random();
    applyReset();
    for (int n = 0; n < 600; n++) begin
      dispatchValid = ($urandom_range(0, 2) != 0);
      ready1 = $urandom_range(0, 1) == 1; ready2 = $urandom_range(0, 1) == 1;
      value1 = $urandom; value2 = $urandom;
      rob1 = ROB_W'($urandom_range(0, 7)); rob2 = ROB_W'($urandom_range(0, 7));
      robInstr = ROB_W'($urandom_range(0, 7)); aluControl = CTRL_W'($urandom_range(0, 15));
      cdbValid = $urandom_range(0, 1) == 1; cdbRob = ROB_W'($urandom_range(0, 7)); cdbValue = $urandom;
      flush = ($urandom_range(0, 39) == 0); execute = ($urandom_range(0, 3) != 0);
      tick();
      total++; if (issueValid !== mValid || issueRob !== mRob || issueInfo !== mInfo) begin bad++; $display("[TB] FAIL rand.issue@%0d got=%0h/%0h/%0h want=%0h/%0h/%0h", n, issueValid, issueRob, issueInfo, mValid, mRob, mInfo); end
      total++; if (issueSrc1 !== mS1 || issueSrc2 !== mS2) begin bad++; $display("[TB] FAIL rand.src@%0d got=%0h/%0h want=%0h/%0h", n, issueSrc1, issueSrc2, mS1, mS2); end
      total++; if (freeCount !== CNT_W'(DEPTH - mq.size())) begin bad++; $display("[TB] FAIL rand.free@%0d got=%0d want=%0d", n, freeCount, DEPTH - mq.size()); end
      total++; if (empty !== (mq.size() == 0) || dispatchReady !== (mq.size() < DEPTH)) begin bad++; $display("[TB] FAIL rand.flags@%0d got=%0b%0b want=%0b%0b", n, empty, dispatchReady, mq.size() == 0, mq.size() < DEPTH); end
    end
  endtask

  initial begin
    setIdle();
    test_reset();
    test_basic_issue();
    test_cdb_wakeup();
    test_age_order();
    test_full();
    test_stall();
    test_flush_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_rs_queue.md
Name: alu_rs_queue

Overview:
- Parametrised ALU reservation station for the out-of-order core; successor to the fixed 4-entry ALU station.
- Holds up to DEPTH dispatched ALU ops, captures missing operands from the common data bus, and selects the oldest ready entry.
- Presents the selected op on registered outputs to the ALU.
- Adds internal allocation, age-ordered select, same-cycle CDB bypass at dispatch, a downstream stall input and occupancy reporting.

Parameters:
WIDTH, 32, operand width in bits
ROB_W, 3, ROB tag width in bits
CTRL_W, 4, ALU control width in bits
DEPTH, 8, number of entries (>=2)
CNT_W, $clog2(DEPTH+1), width of freeCount

Ports:
clk  in  1  clock; all state updates on its rising edge
globalReset  in  1  asynchronous, active-low reset
dispatchValid  in  1  dispatch request
dispatchReady  out  1  at least one entry free
ready1, ready2  in  1 each  operand already valid
value1, value2  in  WIDTH each  operand values (used when ready)
rob1, rob2  in  ROB_W each  producer tags (used when not ready)
robInstr  in  ROB_W  destination ROB tag of the dispatched op
aluControl  in  CTRL_W  ALU operation
cdbValid  in  1  CDB broadcast valid
cdbRob  in  ROB_W  CDB tag
cdbValue  in  WIDTH  CDB value
flush  in  1  mispredict commit (clear & validCommit)
execute  in  1  ALU can accept an op this cycle
issueValid  out  1  issue registers hold a real op
issueRob  out  ROB_W  ROB tag of the issued op
issueInfo  out  CTRL_W  control of the issued op; all ones when bubble
issueSrc1, issueSrc2  out  WIDTH each  issued operands
freeCount  out  CNT_W  number of free entries
empty  out  1  no valid entries

Behaviour:
- Reset (globalReset=0, asynchronous):
  - all entries invalid; age state cleared.
  - issueValid=0, issueInfo='1, issueRob=0, issueSrc1=0, issueSrc2=0.
  - freeCount=DEPTH, empty=1, dispatchReady=1.
  - Takes effect immediately, mid-operation included; release is synchronous to clk.
- Entry state: valid, rdy1/rdy2, tag1/tag2, val1/val2, rob, ctrl.
- Allocation:
  - on dispatchValid & dispatchReady & !flush, write the lowest-index free entry.
  - dispatchReady = (freeCount != 0), computed from current state only. A slot freed by issue in the same cycle is not reusable until the next cycle.
  - dispatchValid while full is ignored (no corruption).
- Dispatch bypass: if an operand is not ready but cdbValid and cdbRob equals its tag in the dispatch cycle, the entry stores cdbValue with that operand marked ready.
- Wakeup: each valid entry with a not-ready operand whose tag equals cdbRob while cdbValid latches cdbValue and sets the ready bit. Both operands may wake in the same cycle.
- Request: an entry requests when it is valid and both ready bits are set, using registered state. Consequently a wakeup at edge t makes the entry selectable in the cycle after t, never combinationally.
- Age order:
  - an N×N age matrix; bit [i][j]=1 means entry j is older than entry i.
  - on allocating entry i, set row i to the current valid vector and clear column i.
  - select = the requesting entry with no requesting older entry (exactly one-hot).
- Issue (at the rising edge, when not flush):
  - execute=1 and a request exists: load issue registers from the selected entry, issueValid=1, free the entry at the same edge.
  - execute=1 and no request: load the bubble (issueValid=0, issueInfo='1, other issue outputs 0).
  - execute=0: issue registers hold and no entry is freed.
- Flush: at the edge, invalidate all entries, load the bubble and ignore dispatch. Flush has priority over dispatch, wakeup and issue.
- Simultaneous events: dispatch, wakeup and issue of different entries all take effect at one edge. freeCount_next = freeCount - alloc + issued.
- Width rules: tag comparisons use all ROB_W bits; no arithmetic is performed on operands.

Test Plan:
1. Reset then dispatch op (ready1=1,value1=5,ready2=1,value2=7,robInstr=2,aluControl=3) with execute=1 -> one edge later issueValid=1, issueSrc1=5, issueSrc2=7, issueRob=2, issueInfo=3; freeCount returns to DEPTH.
2. Dispatch with rob2=4 not ready; the next cycle cdbValid, cdbRob=4, cdbValue=99 -> no issue at the wakeup edge; issueSrc2=99 at the following edge. Repeat with the CDB in the dispatch cycle -> issues one edge after dispatch.
3. Dispatch ops A(rob 1), B(rob 2), C(rob 3), all waiting on tag 6; broadcast tag 6 -> issue order is rob 1, 2, 3 on consecutive edges, regardless of entry index (pre-fill to force A into a higher slot).
4. Fill DEPTH entries, none ready -> dispatchReady=0, freeCount=0; extra dispatch is ignored; after one issue, dispatchReady=1 the next cycle.
5. Ready op with execute=0 for 3 cycles -> issue outputs unchanged, entry retained; execute=1 -> issues the op.
6. Entries pending plus flush=1 at the same edge as dispatch and CDB -> empty=1, freeCount=DEPTH, issueValid=0, issueInfo=4'b1111. Assert globalReset=0 between edges -> outputs go to the bubble immediately.
